// File: rtl/pc_lut_pkg.sv
// rtl/pc_lut_pkg.sv - shared constants and types for the branch-target encoder
package pc_lut_pkg;

  localparam int D     = 12;
  localparam int N     = 32;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} enc_state_t;

  typedef struct packed {
    logic         valid;
    logic [D-1:0] target;
  } tgt_entry_t;

endpackage

// File: rtl/pc_target_table.sv
// rtl/pc_target_table.sv - N-entry target register file
// One write port, clear-all with priority over writes, one asynchronous read port.
module pc_target_table #(
  parameter int D     = 12,
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [D-1:0]     wr_target,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [D-1:0]     rd_target
);

  logic [N-1:0] valid_q;
  logic [D-1:0] target_q [N];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) target_q[i] <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      target_q[wr_idx] <= wr_target;
    end
  end

  // Pre-edge contents: a same-cycle write is not visible to this read.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/pc_target_encoder.sv
// rtl/pc_target_encoder.sv - reverse lookup of a target address to its table index
// Sequential scan from index 0; the lowest matching valid entry wins.
module pc_target_encoder
  import pc_lut_pkg::*;
#(
  parameter int D = 12,
  parameter int N = 32
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [D-1:0]         wr_target,
  input  logic                 clr_all,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [D-1:0]         req_target,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_idx,
  output logic                 rsp_hit,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  enc_state_t    state;
  logic [D-1:0]  key;
  logic [IW-1:0] scan_idx;
  logic          rd_valid;
  logic [D-1:0]  rd_target;
  logic          match;

  pc_target_table #(
    .D    (D),
    .N    (N),
    .IDX_W(IW)
  ) u_table (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_target(wr_target),
    .clr_all  (clr_all),
    .rd_idx   (scan_idx),
    .rd_valid (rd_valid),
    .rd_target(rd_target)
  );

  assign match = rd_valid && (rd_target == key);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      key       <= '0;
      scan_idx  <= '0;
      rsp_valid <= 1'b0;
      rsp_idx   <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            key      <= req_target;
            scan_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_idx   <= scan_idx;
            rsp_hit   <= 1'b1;
          end else if (scan_idx == IW'(N - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_idx   <= '0;
            rsp_hit   <= 1'b0;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        RESP: begin
          // Result held stable until the consumer takes it.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule
